// File: rtl/pc_fetch.sv
// ---------------------------------------------------------------------------
// pc_fetch
//
// Program-counter register and instruction-fetch sequencer for the MIPS
// datapath. The block holds the current PC, fetches the word at that PC over
// a valid/ready request plus a response handshake, holds the fetched word
// for decode, and commits next_pc only when decode accepts the held word.
// Only one fetch is ever outstanding.
//
// A commit to a misaligned next_pc parks the block in a fault state that only
// reset leaves. The PC is loaded verbatim: there is no arithmetic here.
//
// Parameters:
//   RESET_PC         PC loaded on reset (not alignment-checked)
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   reset            synchronous, active-high reset
//   next_pc          next instruction address, sampled only on commit
//   cur_pc           registered current PC
//   imem_req_valid   fetch request valid (high only in the request state)
//   imem_req_addr    fetch address, always equal to cur_pc
//   imem_req_ready   memory accepts the request this cycle
//   imem_resp_valid  response data valid this cycle
//   imem_resp_data   instruction word from memory
//   instr            held instruction word
//   instr_valid      instr is valid for cur_pc
//   instr_ready      decode consumes instr this cycle
//   fetch_fault      sticky misaligned-PC fault
// ---------------------------------------------------------------------------
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] next_pc,
   output logic [31:0] cur_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        fetch_fault
);

   typedef enum logic [1:0] {
      ST_REQ   = 2'b00,
      ST_WAIT  = 2'b01,
      ST_HOLD  = 2'b10,
      ST_FAULT = 2'b11
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        instr_vld_q, instr_vld_d;
   logic        fault_q, fault_d;

   // Next-state and datapath update; every register holds unless its state
   // says otherwise, so inputs outside their owning state are ignored.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      instr_vld_d = instr_vld_q;
      fault_d     = fault_q;

      case (state_q)
         ST_REQ: begin
            if (imem_req_ready) begin
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
            // No timeout: the memory is trusted to answer eventually.
            if (imem_resp_valid) begin
               instr_d     = imem_resp_data;
               instr_vld_d = 1'b1;
               state_d     = ST_HOLD;
            end
         end

         ST_HOLD: begin
            if (instr_ready) begin
               instr_vld_d = 1'b0;
               pc_d        = next_pc;
               if (next_pc[1:0] == 2'b00) begin
                  state_d = ST_REQ;
               end else begin
                  // Keep the misaligned PC visible for debug and stop fetching.
                  fault_d = 1'b1;
                  state_d = ST_FAULT;
               end
            end
         end

         ST_FAULT: begin
            instr_vld_d = 1'b0;
            fault_d     = 1'b1;
         end

         default: begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_REQ;
         pc_q        <= RESET_PC;
         instr_q     <= 32'h0000_0000;
         instr_vld_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         instr_vld_q <= instr_vld_d;
         fault_q     <= fault_d;
      end
   end

   // Request valid is decoded from registered state only, so the request and
   // its address stay stable until the memory accepts them.
   assign imem_req_valid = (state_q == ST_REQ);
   assign imem_req_addr  = pc_q;
   assign cur_pc         = pc_q;
   assign instr          = instr_q;
   assign instr_valid    = instr_vld_q;
   assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] next_pc;
   logic [31:0] cur_pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic        fetch_fault;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pc_fetch #(.RESET_PC(RST_PC)) dut (
      .clk             (clk),
      .reset           (reset),
      .next_pc         (next_pc),
      .cur_pc          (cur_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .instr           (instr),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .fetch_fault     (fetch_fault)
   );

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      instr_ready     = 1'b0;
      next_pc         = 32'h0;
   endtask

   // Memory contents used by the reference: a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
   endfunction

   task automatic test_reset();
      reset           = 1'b1;
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b1;
      imem_resp_data  = $urandom;
      instr_ready     = 1'b1;
      next_pc         = $urandom;
      tick();
      reset = 1'b0;
      idle_inputs();
      checks++; if (cur_pc !== RST_PC) begin failures++; $display("FAIL reset_cur_pc: got %h want %h", cur_pc, RST_PC); end
      checks++; if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", instr); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
      checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL reset_fault: got %b want 0", fetch_fault); end
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin failures++; $display("FAIL reset_req: valid=%b addr=%h want 1/%h", imem_req_valid, imem_req_addr, RST_PC); end
   endtask

   task automatic test_zero_wait();
      imem_req_ready = 1'b1;
      tick();
      checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL zw_wait: req_valid=%b instr_valid=%b want 0/0", imem_req_valid, instr_valid); end
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h2001_0005;
      tick();
      checks++; if (instr_valid !== 1'b1 || instr !== 32'h2001_0005) begin failures++; $display("FAIL zw_instr: valid=%b instr=%h want 1/20010005", instr_valid, instr); end
      checks++; if (cur_pc !== 32'h0) begin failures++; $display("FAIL zw_pc_hold: got %h want 0", cur_pc); end
      imem_resp_valid = 1'b0;
      instr_ready     = 1'b1;
      next_pc         = 32'h4;
      tick();
      instr_ready = 1'b0;
      checks++; if (cur_pc !== 32'h4 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin failures++; $display("FAIL zw_commit: pc=%h req=%b addr=%h want 4/1/4", cur_pc, imem_req_valid, imem_req_addr); end
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL zw_commit_valid: got %b want 0", instr_valid); end
   endtask

   task automatic test_stall();
      logic [31:0] d;
      d = $urandom;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin failures++; $display("FAIL stall_req_hold[%0d]: valid=%b addr=%h want 1/4", i, imem_req_valid, imem_req_addr); end
      end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_wait[%0d]: instr_valid=%b req_valid=%b want 0/0", i, instr_valid, imem_req_valid); end
         tick();
      end
      imem_resp_valid = 1'b1;
      imem_resp_data  = d;
      checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stall_pre_resp: got %b want 0", instr_valid); end
      tick();
      imem_resp_valid = 1'b0;
      checks++; if (instr_valid !== 1'b1 || instr !== d) begin failures++; $display("FAIL stall_resp: valid=%b instr=%h want 1/%h", instr_valid, instr, d); end
   endtask

   task automatic test_hold_stable();
      logic [31:0] held;
      held = instr;
      for (int i = 0; i < 5; i++) begin
         next_pc         = (i % 2 == 0) ? 32'h8 : 32'h100;
         imem_resp_valid = 1'b1;
         imem_resp_data  = ~held;
         tick();
         checks++; if (instr !== held || instr_valid !== 1'b1 || cur_pc !== 32'h4) begin failures++; $display("FAIL hold_stable[%0d]: instr=%h valid=%b pc=%h want %h/1/4", i, instr, instr_valid, cur_pc, held); end
      end
      imem_resp_valid = 1'b0;
      instr_ready     = 1'b1;
      next_pc         = 32'h100;
      tick();
      instr_ready = 1'b0;
      checks++; if (cur_pc !== 32'h100 || imem_req_addr !== 32'h100 || imem_req_valid !== 1'b1) begin failures++; $display("FAIL hold_commit: pc=%h addr=%h req=%b want 100/100/1", cur_pc, imem_req_addr, imem_req_valid); end
   endtask

   task automatic test_fault();
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hDEAD_BEEF;
      tick();
      imem_resp_valid = 1'b0;
      instr_ready     = 1'b1;
      next_pc         = 32'h0000_0102;
      tick();
      checks++; if (fetch_fault !== 1'b1 || cur_pc !== 32'h102) begin failures++; $display("FAIL fault_enter: fault=%b pc=%h want 1/102", fetch_fault, cur_pc); end
      for (int i = 0; i < 10; i++) begin
         checks++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || fetch_fault !== 1'b1 || cur_pc !== 32'h102) begin failures++; $display("FAIL fault_park[%0d]: req=%b ivalid=%b fault=%b pc=%h want 0/0/1/102", i, imem_req_valid, instr_valid, fetch_fault, cur_pc); end
         imem_req_ready  = 1'($urandom);
         imem_resp_valid = 1'($urandom);
         imem_resp_data  = $urandom;
         instr_ready     = 1'($urandom);
         next_pc         = $urandom & 32'hFFFF_FFFC;
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle_inputs();
      checks++; if (cur_pc !== RST_PC || imem_req_valid !== 1'b1 || fetch_fault !== 1'b0 || instr_valid !== 1'b0) begin failures++; $display("FAIL fault_reset: pc=%h req=%b fault=%b ivalid=%b want 0/1/0/0", cur_pc, imem_req_valid, fetch_fault, instr_valid); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      // spurious response while requesting
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'h1234_5678;
      tick();
      checks++; if (instr !== 32'h0 || instr_valid !== 1'b0 || imem_req_valid !== 1'b1) begin failures++; $display("FAIL spur_req: instr=%h valid=%b req=%b want 0/0/1", instr, instr_valid, imem_req_valid); end
      imem_resp_valid = 1'b0;
      // reset while waiting, with a response on the same edge
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready  = 1'b0;
      reset           = 1'b1;
      imem_resp_valid = 1'b1;
      tick();
      reset           = 1'b0;
      imem_resp_valid = 1'b0;
      checks++; if (cur_pc !== RST_PC || instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || instr !== 32'h0) begin failures++; $display("FAIL reset_in_wait: pc=%h ivalid=%b req=%b instr=%h want 0/0/1/0", cur_pc, instr_valid, imem_req_valid, instr); end
      // reach hold, then check a spurious response and a reset there
      d = $urandom;
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b1;
      imem_resp_data  = d;
      tick();
      imem_resp_data = ~d;
      tick();
      imem_resp_valid = 1'b0;
      checks++; if (instr !== d || instr_valid !== 1'b1) begin failures++; $display("FAIL spur_hold: instr=%h valid=%b want %h/1", instr, instr_valid, d); end
      reset       = 1'b1;
      instr_ready = 1'b1;
      next_pc     = 32'h8;
      tick();
      reset = 1'b0;
      idle_inputs();
      checks++; if (cur_pc !== RST_PC || instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || instr !== 32'h0) begin failures++; $display("FAIL reset_in_hold: pc=%h ivalid=%b req=%b instr=%h want 0/0/1/0", cur_pc, instr_valid, imem_req_valid, instr); end
   endtask

   task automatic test_jump_seq();
      logic [31:0] seq [5];
      logic [31:0] d;
      int          commits;
      seq[0] = 32'h0; seq[1] = 32'h4; seq[2] = 32'h0040_0000; seq[3] = 32'h3C; seq[4] = 32'h40;
      commits = 0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle_inputs();
      for (int i = 0; i < 4; i++) begin
         for (int k = $urandom_range(0, 3); k > 0; k--) begin
            tick();
         end
         checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== seq[i]) begin failures++; $display("FAIL jump_req[%0d]: valid=%b addr=%h want 1/%h", i, imem_req_valid, imem_req_addr, seq[i]); end
         imem_req_ready = 1'b1;
         tick();
         imem_req_ready = 1'b0;
         for (int k = $urandom_range(0, 3); k > 0; k--) begin
            tick();
         end
         d = mem_word(seq[i]);
         imem_resp_valid = 1'b1;
         imem_resp_data  = d;
         tick();
         imem_resp_valid = 1'b0;
         checks++; if (instr_valid !== 1'b1 || instr !== d) begin failures++; $display("FAIL jump_instr[%0d]: valid=%b instr=%h want 1/%h", i, instr_valid, instr, d); end
         for (int k = $urandom_range(0, 3); k > 0; k--) begin
            next_pc = $urandom;
            tick();
         end
         instr_ready = 1'b1;
         next_pc     = seq[i+1];
         tick();
         instr_ready = 1'b0;
         commits++;
         checks++; if (cur_pc !== seq[i+1] || instr_valid !== 1'b0) begin failures++; $display("FAIL jump_commit[%0d]: pc=%h ivalid=%b want %h/0", i, cur_pc, instr_valid, seq[i+1]); end
      end
      checks++; if (commits !== 4 || fetch_fault !== 1'b0) begin failures++; $display("FAIL jump_count: commits=%0d fault=%b want 4/0", commits, fetch_fault); end
   endtask

   // Free-running random handshakes checked against a transaction-level
   // model: one fetch outstanding, word held until consumed, PC from commit.
   task automatic test_back_to_back();
      logic [31:0] model_pc, pend_addr, model_instr, sent_np, sent_data, acc_addr;
      logic        pending, model_valid, accept, respond, commit;
      int          commits;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle_inputs();
      model_pc = RST_PC; pending = 1'b0; model_valid = 1'b0; model_instr = 32'h0;
      pend_addr = 32'h0; commits = 0;
      for (int c = 0; c < 400; c++) begin
         checks++; if (imem_req_valid !== (!pending && !model_valid)) begin failures++; $display("FAIL b2b_req_valid[%0d]: got %b want %b", c, imem_req_valid, !pending && !model_valid); end
         imem_req_ready  = ($urandom_range(0, 2) != 0);
         imem_resp_valid = ($urandom_range(0, 2) != 0);
         imem_resp_data  = pending ? mem_word(pend_addr) : $urandom;
         instr_ready     = ($urandom_range(0, 2) != 0);
         commit          = model_valid && instr_ready;
         next_pc         = commit ? ($urandom & 32'h00FF_FFFC) : $urandom;
         accept          = imem_req_valid && imem_req_ready;
         acc_addr        = imem_req_addr;
         respond         = pending && imem_resp_valid;
         sent_np         = next_pc;
         sent_data       = imem_resp_data;
         tick();
         if (accept) begin
            checks++; if (acc_addr !== model_pc) begin failures++; $display("FAIL b2b_req_addr[%0d]: got %h want %h", c, acc_addr, model_pc); end
            pending   = 1'b1;
            pend_addr = acc_addr;
         end
         if (respond) begin
            pending     = 1'b0;
            model_valid = 1'b1;
            model_instr = sent_data;
         end
         if (commit) begin
            model_valid = 1'b0;
            model_pc    = sent_np;
            commits++;
         end
         checks++; if (cur_pc !== model_pc || instr_valid !== model_valid || fetch_fault !== 1'b0) begin failures++; $display("FAIL b2b_state[%0d]: pc=%h ivalid=%b fault=%b want %h/%b/0", c, cur_pc, instr_valid, fetch_fault, model_pc, model_valid); end
         if (model_valid) begin
            checks++; if (instr !== model_instr) begin failures++; $display("FAIL b2b_instr[%0d]: got %h want %h", c, instr, model_instr); end
         end
      end
      idle_inputs();
      checks++; if (commits < 10) begin failures++; $display("FAIL b2b_progress: commits=%0d want >=10", commits); end
   endtask

   initial begin
      reset = 1'b0;
      idle_inputs();
      #2;
      test_reset();
      test_zero_wait();
      test_stall();
      test_hold_stable();
      test_fault();
      test_reset_mid();
      test_jump_seq();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
